// File: rtl/debug_trace_arbiter.sv
// debug_trace_arbiter: merges the WB register-retire trace and the MEM store trace
// into one program-ordered stream through a small FIFO drained over valid/ready.
// Optional feature macro: DEBUG_TRACE_STALL_EN. When it is defined, a registered stall
// request is raised while the FIFO is close to full. When it is undefined, o_stall_req
// is tied to 0 and overflow is handled only by dropping and counting events.
module debug_trace_arbiter #(
  parameter int DEPTH  = 8,
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wb_valid,
  input  logic [PC_W-1:0]   i_wb_pc,
  input  logic [4:0]        i_wb_rd,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_wb_is_load,
  input  logic [DATA_W-1:0] i_wb_addr,
  input  logic              i_st_valid,
  input  logic [PC_W-1:0]   i_st_pc,
  input  logic [DATA_W-1:0] i_st_addr,
  input  logic [DATA_W-1:0] i_st_data,
  output logic              o_trace_valid,
  input  logic              i_trace_ready,
  output logic [1:0]        o_trace_kind,
  output logic [PC_W-1:0]   o_trace_pc,
  output logic [4:0]        o_trace_rd,
  output logic [DATA_W-1:0] o_trace_data,
  output logic [DATA_W-1:0] o_trace_addr,
  output logic [CNT_W-1:0]  o_drop_count,
  output logic              o_stall_req
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [1:0] K_REG   = 2'd0;
  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;
  localparam logic [CW:0] ONE    = (CW+1)'(1);
  localparam logic [CW:0] TWO    = (CW+1)'(2);
  localparam logic [CW:0] DEPTHW = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [1:0]        kind;
    logic [PC_W-1:0]   pc;
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] addr;
  } entry_t;

  entry_t            r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CNT_W-1:0]  r_drop;
  logic              r_stall;

  logic              w_pop;
  logic [CW:0]       w_free;
  logic              w_wb_push, w_st_push;
  logic [1:0]        w_npush, w_drops;
  logic [CW-1:0]     w_count_next;
  logic [CNT_W:0]    w_drop_sum;
  entry_t            w_wb_ent, w_st_ent;

  // Admission: WB (older instruction) always takes the first free slot, store the next.
  always_comb begin
    w_pop     = (r_count != '0) && i_trace_ready;
    w_free    = DEPTHW - {1'b0, r_count} + {{CW{1'b0}}, w_pop};
    w_wb_push = i_wb_valid && (w_free >= ONE);
    w_st_push = i_st_valid && (i_wb_valid ? (w_free >= TWO) : (w_free >= ONE));
    w_npush   = {1'b0, w_wb_push} + {1'b0, w_st_push};
    w_drops   = {1'b0, i_wb_valid && !w_wb_push} + {1'b0, i_st_valid && !w_st_push};
    w_count_next = r_count + CW'(w_npush) - CW'(w_pop);
    w_drop_sum   = {1'b0, r_drop} + (CNT_W+1)'(w_drops);

    w_wb_ent.kind = i_wb_is_load ? K_LOAD : K_REG;
    w_wb_ent.pc   = i_wb_pc;
    w_wb_ent.rd   = i_wb_rd;
    w_wb_ent.data = i_wb_data;
    w_wb_ent.addr = i_wb_is_load ? i_wb_addr : '0;

    w_st_ent.kind = K_STORE;
    w_st_ent.pc   = i_st_pc;
    w_st_ent.rd   = '0;
    w_st_ent.data = i_st_data;
    w_st_ent.addr = i_st_addr;
  end

  // FIFO storage; cleared on reset so the head payload reads 0 out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wb_push) r_mem[r_wr_ptr] <= w_wb_ent;
      if (w_st_push) r_mem[w_wb_push ? r_wr_ptr + AW'(1) : r_wr_ptr] <= w_st_ent;
    end
  end

  // Pointers, occupancy and saturating drop counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_npush);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count  <= w_count_next;
      r_drop   <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
    end
  end

`ifdef DEBUG_TRACE_STALL_EN
  localparam logic [CW-1:0] STALL_TH = CW'(DEPTH - 2);
  // Stall leaves room for one more cycle of two events already in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_stall <= 1'b0;
    else          r_stall <= (w_count_next >= STALL_TH);
  end
`else
  assign r_stall = 1'b0;
`endif

  assign o_trace_valid = (r_count != '0);
  assign o_trace_kind  = r_mem[r_rd_ptr].kind;
  assign o_trace_pc    = r_mem[r_rd_ptr].pc;
  assign o_trace_rd    = r_mem[r_rd_ptr].rd;
  assign o_trace_data  = r_mem[r_rd_ptr].data;
  assign o_trace_addr  = r_mem[r_rd_ptr].addr;
  assign o_drop_count  = r_drop;
  assign o_stall_req   = r_stall;

endmodule

// File: tb/tb_debug_trace_arbiter.sv
// Scoreboard bench for debug_trace_arbiter: stimulus pushes expected entries,
// a negedge monitor pops and compares on every accepted trace handshake.
module tb_debug_trace_arbiter;
  localparam int EW = 2 + 32 + 5 + 32 + 32;

  logic        clk = 0, rst_n = 0;
  logic        wb_valid = 0, wb_is_load = 0, st_valid = 0, trace_ready = 0;
  logic [31:0] wb_pc = 0, wb_data = 0, wb_addr = 0, st_pc = 0, st_addr = 0, st_data = 0;
  logic [4:0]  wb_rd = 0;
  logic        trace_valid, stall_req;
  logic [1:0]  trace_kind;
  logic [31:0] trace_pc, trace_data, trace_addr;
  logic [4:0]  trace_rd;
  logic [15:0] drop_count;

  logic [EW-1:0] sb [$];
  int errors = 0, checks = 0, popped = 0;

  debug_trace_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_valid(wb_valid), .i_wb_pc(wb_pc), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .i_wb_is_load(wb_is_load), .i_wb_addr(wb_addr),
    .i_st_valid(st_valid), .i_st_pc(st_pc), .i_st_addr(st_addr), .i_st_data(st_data),
    .o_trace_valid(trace_valid), .i_trace_ready(trace_ready), .o_trace_kind(trace_kind),
    .o_trace_pc(trace_pc), .o_trace_rd(trace_rd), .o_trace_data(trace_data),
    .o_trace_addr(trace_addr), .o_drop_count(drop_count), .o_stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: handshake is sampled half a cycle before the accepting edge.
  always @(negedge clk) begin
    if (rst_n && trace_valid && trace_ready) begin
      logic [EW-1:0] got, exp;
      got = {trace_kind, trace_pc, trace_rd, trace_data, trace_addr};
      checks++;
      popped++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: got entry 0x%0h expected none", got);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL sb_entry: got k%0d pc 0x%0h rd %0d d 0x%0h a 0x%0h expected k%0d pc 0x%0h rd %0d d 0x%0h a 0x%0h",
                   got[EW-1 -: 2], got[100:69], got[68:64], got[63:32], got[31:0],
                   exp[EW-1 -: 2], exp[100:69], exp[68:64], exp[63:32], exp[31:0]);
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_ent(input logic [1:0] k, input logic [31:0] pc, input logic [4:0] rd,
                            input logic [31:0] d, input logic [31:0] a);
    sb.push_back({k, pc, rd, d, a});
  endtask

  // Drive one cycle of events, then idle the event inputs.
  task automatic ev(input logic wv, input logic ld, input logic [31:0] pc, input logic [4:0] rd,
                    input logic [31:0] d, input logic [31:0] la,
                    input logic sv, input logic [31:0] spc, input logic [31:0] sa, input logic [31:0] sd);
    wb_valid = wv; wb_is_load = ld; wb_pc = pc; wb_rd = rd; wb_data = d; wb_addr = la;
    st_valid = sv; st_pc = spc; st_addr = sa; st_data = sd;
    cyc();
    wb_valid = 0; st_valid = 0; wb_is_load = 0;
  endtask

  task automatic drain();
    int n;
    trace_ready = 1;
    n = 0;
    while ((trace_valid || sb.size() != 0) && n < 40) begin cyc(); n++; end
    chk("drain_done", 64'(n < 40), 64'd1);
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    // 1: reset with garbage inputs
    wb_valid = 1; st_valid = 1; wb_pc = 32'hDEAD; st_pc = 32'hBEEF; trace_ready = 1;
    cyc(3);
    chk("rst_valid", 64'(trace_valid), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_stall", 64'(stall_req), 64'd0);
    chk("rst_pc", 64'(trace_pc), 64'd0);
    wb_valid = 0; st_valid = 0; trace_ready = 0;
    rst_n = 1;
    cyc();

    // 2: simultaneous WB + store, WB first
    trace_ready = 1;
    expect_ent(2'd0, 32'h10, 5'd5, 32'hAAAA, 32'h0);
    expect_ent(2'd2, 32'h14, 5'd0, 32'h55, 32'h200);
    ev(1, 0, 32'h10, 5'd5, 32'hAAAA, 32'h777, 1, 32'h14, 32'h200, 32'h55);
    chk("lat1_valid", 64'(trace_valid), 64'd1);
    chk("lat1_pc", 64'(trace_pc), 64'h10);
    cyc();
    chk("n2_kind", 64'(trace_kind), 64'd2);
    drain();

    // 5: load carries address, plain REG reports address 0
    expect_ent(2'd1, 32'h20, 5'd7, 32'h1234, 32'h100);
    expect_ent(2'd0, 32'h24, 5'd8, 32'h5678, 32'h0);
    ev(1, 1, 32'h20, 5'd7, 32'h1234, 32'h100, 0, 0, 0, 0);
    ev(1, 0, 32'h24, 5'd8, 32'h5678, 32'h999, 0, 0, 0, 0);
    drain();

    // 3: fill with 4 dual cycles, then overflow
    trace_ready = 0;
    for (int i = 0; i < 4; i++) begin
      expect_ent(2'd0, 32'h40 + 8*i, 5'(i + 1), 32'h100 + i, 32'h0);
      expect_ent(2'd2, 32'h44 + 8*i, 5'd0, 32'h200 + i, 32'h300 + i);
      ev(1, 0, 32'h40 + 8*i, 5'(i + 1), 32'h100 + i, 0, 1, 32'h44 + 8*i, 32'h300 + i, 32'h200 + i);
    end
    chk("fill_nodrop", 64'(drop_count), 64'd0);
    ev(1, 0, 32'hBAD0, 5'd9, 0, 0, 1, 32'hBAD4, 0, 0);
    chk("ovf_drop2", 64'(drop_count), 64'd2);
    // pop one to reach count 7, then dual event keeps WB only
    trace_ready = 1; cyc(); trace_ready = 0;
    expect_ent(2'd0, 32'h60, 5'd10, 32'h600, 32'h0);
    ev(1, 0, 32'h60, 5'd10, 32'h600, 0, 1, 32'h64, 32'h640, 32'h641);
    chk("c7_drop3", 64'(drop_count), 64'd3);

    // 4: full + pop + one push: accepted, still full
    trace_ready = 1;
    expect_ent(2'd0, 32'h70, 5'd11, 32'h700, 32'h0);
    ev(1, 0, 32'h70, 5'd11, 32'h700, 0, 0, 0, 0, 0);
    trace_ready = 0;
    chk("full_pop_push_drop", 64'(drop_count), 64'd3);
    ev(1, 0, 32'hBAD8, 5'd12, 0, 0, 0, 0, 0, 0);
    chk("still_full_drop", 64'(drop_count), 64'd4);
    drain();
    chk("popped_total", 64'(popped), 64'd14);

`ifdef DEBUG_TRACE_STALL_EN
    // 6: stall rises at count 6, events stop, then falls on first pop
    begin
      int n;
      logic [31:0] base;
      trace_ready = 0;
      n = 0;
      base = drop_count;
      while (!stall_req && n < 20) begin
        expect_ent(2'd0, 32'h800 + 4*n, 5'd1, 32'(n), 32'h0);
        ev(1, 0, 32'h800 + 4*n, 5'd1, 32'(n), 0, 0, 0, 0, 0);
        n++;
      end
      chk("stall_at6", 64'(n), 64'd6);
      chk("stall_nodrop", 64'(drop_count), 64'(base));
      trace_ready = 1; cyc();
      chk("stall_fall", 64'(stall_req), 64'd0);
      drain();
    end
`else
    chk("stall_tied0", 64'(stall_req), 64'd0);
`endif

    // mid-stream reset discards queued entries
    trace_ready = 0;
    ev(1, 0, 32'h900, 5'd2, 32'h1, 0, 1, 32'h904, 32'h2, 32'h3);
    chk("pre_rst_valid", 64'(trace_valid), 64'd1);
    rst_n = 0; #1;
    chk("mid_rst_valid", 64'(trace_valid), 64'd0);
    chk("mid_rst_drop", 64'(drop_count), 64'd0);
    cyc(); rst_n = 1; cyc(2);
    chk("post_rst_valid", 64'(trace_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
